// File: rtl/ds_cic_decimator.sv
// Third-order CIC decimator turning the 4-bit delta-sigma stream back into PCM.
// Optional rail-clip indicator enabled by defining DS_DECIM_CLIP_FLAG_EN.
module ds_cic_decimator #(
  parameter int LOG2_R = 4,
  parameter int IN_W   = 4,
  parameter int OUT_W  = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  data_in,
  input  logic             in_valid,
`ifdef DS_DECIM_CLIP_FLAG_EN
  input  logic             clip_clear,
  output logic             clip_flag,
`endif
  output logic [OUT_W-1:0] data_out,
  output logic             out_valid
);

  localparam int ACC_W = IN_W + 3 * LOG2_R;
  localparam int NUM_STAGES = 3;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] tap;
  logic signed [ACC_W-1:0] integ [NUM_STAGES];
  logic signed [ACC_W-1:0] comb  [NUM_STAGES];
  logic [LOG2_R-1:0]       phase;
  logic                    strobe;
  logic                    last_phase;

  assign in_ext     = {{(ACC_W-IN_W){data_in[IN_W-1]}}, data_in};
  assign last_phase = &phase;

  // Each stage owns one integrator and one comb delay; wrap-around is intended.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic signed [ACC_W-1:0] integ_in;
      logic signed [ACC_W-1:0] comb_in;
      logic signed [ACC_W-1:0] integ_q;
      logic signed [ACC_W-1:0] dly_q;

      if (gi == 0) begin : g_first
        assign integ_in = in_ext;
        assign comb_in  = tap;
      end else begin : g_rest
        assign integ_in = integ[gi-1];
        assign comb_in  = comb[gi-1];
      end

      assign integ[gi] = integ_q;
      assign comb[gi]  = comb_in - dly_q;

      always_ff @(posedge clk) begin
        if (!reset) begin
          integ_q <= '0;
          dly_q   <= '0;
        end else begin
          if (in_valid) integ_q <= integ_q + integ_in;
          if (strobe)   dly_q   <= comb_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      tap       <= '0;
      phase     <= '0;
      strobe    <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      strobe    <= in_valid && last_phase;
      out_valid <= strobe;
      if (in_valid) begin
        phase <= phase + 1'b1;
        if (last_phase) tap <= integ[NUM_STAGES-1];
      end
      // Keep the top OUT_W bits of the last comb (arithmetic truncation).
      if (strobe) data_out <= OUT_W'(comb[NUM_STAGES-1] >>> (ACC_W - OUT_W));
    end
  end

`ifdef DS_DECIM_CLIP_FLAG_EN
  localparam logic [IN_W-1:0] MIN_CODE = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] MAX_CODE = {1'b0, {(IN_W-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      clip_flag <= 1'b0;
    end else if (in_valid && (data_in == MIN_CODE || data_in == MAX_CODE)) begin
      clip_flag <= 1'b1;
    end else if (clip_clear) begin
      clip_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ds_cic_decimator.sv
// Scoreboard bench for ds_cic_decimator: stimulus queues expected samples, monitor checks them.
module tb_ds_cic_decimator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  data_in = 4'd0;
  logic        in_valid = 1'b0;
  logic        clip_clear = 1'b0;
  logic [13:0] data_out;
  logic        out_valid;
`ifdef DS_DECIM_CLIP_FLAG_EN
  logic        clip_flag;
`endif

  ds_cic_decimator dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .in_valid  (in_valid),
`ifdef DS_DECIM_CLIP_FLAG_EN
    .clip_clear(clip_clear),
    .clip_flag (clip_flag),
`endif
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0;

  // Hand-derived outputs for constant input x: third difference of x*C(16k-1,3), then >>>2.
  function automatic int exp_val(int x, int frame);
    case (x)
      3:  return (frame == 1) ? 341  : (frame == 2) ? 2347  : (frame == 3) ? 3071  : 3072;
      -8: return (frame == 1) ? -910 : (frame == 2) ? -6260 : (frame == 3) ? -8190 : -8192;
      5:  return (frame == 1) ? 568  : (frame == 2) ? 3912  : (frame == 3) ? 5118  : 5120;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_out_valid edge=%0d data_out=%0d required no strobe",
                 edge_cnt, $signed(data_out));
      end else begin
        mon_e = sb.pop_front();
        if (edge_cnt != mon_e.due || $signed(data_out) != mon_e.val) begin
          failures++;
          $display("FAIL out_sample edge=%0d data_out=%0d required edge=%0d data_out=%0d",
                   edge_cnt, $signed(data_out), mon_e.due, mon_e.val);
        end else begin
          $display("out_sample ok edge=%0d data_out=%0d", edge_cnt, $signed(data_out));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles, logic [3:0] din, logic iv);
    reset    = 1'b0;
    data_in  = din;
    in_valid = iv;
    for (int i = 0; i < cycles; i++) begin
      tick();
      checks++;
      if (data_out !== 14'd0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_state edge=%0d data_out=%0d out_valid=%b required 0/0",
                 edge_cnt, data_out, out_valid);
      end else begin
        $display("reset_state ok edge=%0d", edge_cnt);
      end
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    acc_cnt  = 0;
  endtask

  task automatic send(int x, bit v);
    exp_t e;
    data_in  = x[3:0];
    in_valid = v;
    tick();
    if (v) begin
      acc_cnt++;
      if (acc_cnt % 16 == 0) begin
        e.due = edge_cnt + 1;
        e.val = exp_val(x, acc_cnt / 16);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(string name);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
      sb.delete();
    end else begin
      $display("%s_drain ok", name);
    end
  endtask

  task automatic run(int x, int nsamp, bit toggle, string name);
    for (int i = 0; i < nsamp; i++) begin
      send(x, 1'b1);
      if (toggle) send(x, 1'b0);
    end
    drain(name);
  endtask

`ifdef DS_DECIM_CLIP_FLAG_EN
  task automatic clip_step(int x, logic clr, logic expect_flag, string name);
    clip_clear = clr;
    send(x, 1'b1);
    checks++;
    if (clip_flag !== expect_flag) begin
      failures++;
      $display("FAIL %s clip_flag=%b required %b", name, clip_flag, expect_flag);
    end else begin
      $display("%s ok clip_flag=%b", name, clip_flag);
    end
  endtask
`endif

  initial begin
    do_reset(2, 4'd5, 1'b1);
    run(3, 96, 1'b0, "const_p3");

    do_reset(1, 4'd0, 1'b0);
    run(-8, 96, 1'b0, "const_m8");

    do_reset(1, 4'd0, 1'b0);
    run(3, 96, 1'b1, "toggle_p3");

    // Partial frame, then reset with in_valid still high.
    do_reset(1, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) send(3, 1'b1);
    do_reset(1, 4'd3, 1'b1);
    run(5, 96, 1'b0, "midreset_p5");

`ifdef DS_DECIM_CLIP_FLAG_EN
    do_reset(1, 4'd0, 1'b0);
    clip_step(0, 1'b0, 1'b0, "clip_zero_a");
    clip_step(0, 1'b0, 1'b0, "clip_zero_b");
    clip_step(7, 1'b0, 1'b1, "clip_set_p7");
    clip_step(0, 1'b0, 1'b1, "clip_hold_a");
    clip_step(0, 1'b0, 1'b1, "clip_hold_b");
    clip_step(0, 1'b1, 1'b0, "clip_clear");
    clip_step(-8, 1'b0, 1'b1, "clip_set_m8");
    clip_step(7, 1'b1, 1'b1, "clip_set_wins");
    clip_step(0, 1'b1, 1'b0, "clip_clear_again");
    clip_clear = 1'b0;
    drain("clip");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d required finish", edge_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ds_cic_decimator.md
Name: ds_cic_decimator

Overview:
- Receive-side counterpart of the team's 4-bit delta-sigma modulator: decodes the 4-bit signed modulator stream back into 14-bit signed PCM samples.
- Third-order CIC decimator: three integrators at the input rate, a decimate-by-R tap, three combs at the output rate, then scaling to 14 bits.
- Sits between the modulator output (or loopback) and downstream PCM consumers.

Parameters:
- LOG2_R, 4, log2 of decimation ratio R (R=16 by default); legal range 2..8.
- IN_W, 4, input sample width, signed.
- OUT_W, 14, output sample width, signed.
- ACC_W, IN_W+3*LOG2_R (16 by default), derived width of integrators, combs and tap; must satisfy ACC_W >= OUT_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- data_in  in  IN_W  signed modulator code, -8..+7.
- in_valid  in  1  data_in is consumed at the edge where in_valid=1; there is no backpressure.
- data_out  out  OUT_W  signed decimated sample; holds its value between out_valid pulses.
- out_valid  out  1  single-cycle strobe marking a new data_out.

Behaviour:
- Reset (reset==0 at an edge) clears data_out, out_valid, the three integrators, the three comb delay registers, the tap, the phase counter and the internal strobe to 0. Reset mid-frame discards the partial frame, and the phase restarts at 0.
- Integrators: on each accepted sample (in_valid=1), I1<=I1+sext(data_in), I2<=I2+I1, I3<=I3+I2. Each stage uses pre-edge values, so it is a registered chain. All arithmetic is ACC_W-bit two's-complement modulo, and wrap-around is intended (CIC property). Integrators hold when in_valid=0.
- Phase counter: LOG2_R bits, counts accepted samples only, 0..R-1, and wraps.
- Decimation: at the edge accepting a sample with phase==R-1:
  - tap<=I3 (pre-edge value);
  - internal strobe set for exactly one cycle.
- Combs: at the edge where the strobe is 1, compute the chain in one combinational pass, with each delay register then updated to its stage input:
  - C1=tap-D1;
  - C2=C1-D2;
  - C3=C2-D3.
- Output: at that same edge, data_out<=C3[ACC_W-1 : ACC_W-OUT_W] (arithmetic truncation) and out_valid<=1. At every other edge, out_valid<=0.
- Latency: out_valid is high in the cycle after the second rising edge, counting the edge that accepted the R-th sample as the first.
- in_valid may be held high continuously; out_valid then pulses every R cycles.
- Gain: DC gain is R^3 = 2^(3*LOG2_R). The steady-state output for constant input x is x*2^(3*LOG2_R-(ACC_W-OUT_W)); by default this is x*1024.
- Settling: the first 3 output samples after reset are transient. From the 4th output on, a constant input gives the exact steady-state value.
- Simultaneous events: reset==0 overrides in_valid and the strobe. A sample accepted in the same edge as a comb update proceeds normally.

Optional Feature:
- Macro: DS_DECIM_CLIP_FLAG_EN.
- Defined:
  - adds input clip_clear (1 bit) and output clip_flag (1 bit);
  - clip_flag<=1 at any edge accepting data_in equal to -8 or +7 (modulator rail);
  - clip_flag is cleared by reset or by clip_clear=1;
  - if set and clear occur in the same edge, set wins;
  - reset value 0.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, data_in=5 -> data_out=0, out_valid=0 throughout; first out_valid only after 16 accepted samples following release.
- Constant +3, in_valid=1 continuous, defaults -> out_valid period exactly 16 cycles, single-cycle; data_out=3072 from the 4th pulse onward.
- Constant -8 -> data_out=-8192 (14'h2000) from the 4th pulse; no wrap error despite integrator overflow.
- in_valid toggling 1,0,1,0 with data_in=+3 -> out_valid every 32 cycles; steady data_out=3072; integrators unchanged on in_valid=0 cycles.
- Reset pulled low after 7 samples of a frame, then constant +5 -> first out_valid exactly 16 accepted samples after release; steady data_out=5120.
- With DS_DECIM_CLIP_FLAG_EN: a single data_in=+7 among zeros -> clip_flag=1 after that edge and stays set until clip_clear=1. clip_clear and a +7 sample in the same edge -> flag stays 1.
